// File: rtl/bank_sel_decoder.sv
// Registered one-hot bank select decoder with a loadable, round-robin index pointer.
// Bad loads are rejected with an err pulse; pointer wrap is flagged with a wrap pulse.
module bank_sel_decoder #(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = (1 << SEL_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic               load_valid,
   input  logic [SEL_W-1:0]   load_idx,
   input  logic               step,
   output logic [NUM_OUT-1:0] out,
   output logic [SEL_W-1:0]   cur_idx,
   output logic               wrap,
   output logic               err
);

   localparam logic [SEL_W:0]   LP_NUM  = (SEL_W+1)'(NUM_OUT);
   localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(NUM_OUT - 1);

   logic [SEL_W-1:0]   r_ptr;
   logic [NUM_OUT-1:0] r_out;
   logic               r_wrap;
   logic               r_err;

   logic [SEL_W-1:0]   w_ptr_n;
   logic               w_wrap_n;
   logic               w_err_n;
   logic               w_idx_ok;

   assign w_idx_ok = ({1'b0, load_idx} < LP_NUM);

   always_comb begin
      w_ptr_n  = r_ptr;
      w_wrap_n = 1'b0;
      w_err_n  = 1'b0;
      if (load_valid) begin
         // an out-of-range load also swallows any step this cycle
         if (w_idx_ok) w_ptr_n = load_idx;
         else          w_err_n = 1'b1;
      end else if (mode && step) begin
         if (r_ptr == LP_LAST) begin
            w_ptr_n  = '0;
            w_wrap_n = 1'b1;
         end else begin
            w_ptr_n = r_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_out  <= '0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_ptr  <= w_ptr_n;
         r_out  <= en ? (NUM_OUT'(1) << w_ptr_n) : '0;
         r_wrap <= w_wrap_n;
         r_err  <= w_err_n;
      end
   end

   assign out     = r_out;
   assign cur_idx = r_ptr;
   assign wrap    = r_wrap;
   assign err     = r_err;

endmodule

// File: tb/tb_bank_sel_decoder.sv
// Bench for bank_sel_decoder: NUM_OUT=6 and NUM_OUT=8 instances share stimulus,
// checked against table expectations and an arithmetic pointer model.
module tb_bank_sel_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       load_valid = 1'b0;
   logic [2:0] load_idx = '0;
   logic       step = 1'b0;

   logic [5:0] out6;
   logic [2:0] idx6;
   logic       wrap6, err6;
   logic [7:0] out8;
   logic [2:0] idx8;
   logic       wrap8, err8;

   int n_chk = 0;
   int n_fail = 0;

   int p6 = 0, p8 = 0;
   bit w6 = 0, e6 = 0, w8 = 0, e8 = 0;

   always #5 clk = ~clk;

   bank_sel_decoder #(.SEL_W(3), .NUM_OUT(6)) u6 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
      .load_valid(load_valid), .load_idx(load_idx), .step(step),
      .out(out6), .cur_idx(idx6), .wrap(wrap6), .err(err6)
   );

   bank_sel_decoder #(.SEL_W(3), .NUM_OUT(8)) u8 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
      .load_valid(load_valid), .load_idx(load_idx), .step(step),
      .out(out8), .cur_idx(idx8), .wrap(wrap8), .err(err8)
   );

   typedef struct {
      bit       en;
      bit       mode;
      bit       lv;
      bit [2:0] idx;
      bit       step;
      int       x_idx;
      bit       x_wrap;
      bit       x_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model(input int n, inout int p, output bit w, output bit e);
      w = 0;
      e = 0;
      if (load_valid && int'(load_idx) < n) p = int'(load_idx);
      else if (load_valid) e = 1;
      else if (mode && step) begin
         w = (p == n - 1);
         p = (p + 1) % n;
      end
   endtask

   function automatic logic [31:0] onehot(input int p, input bit e);
      return e ? (32'd1 << p) : 32'd0;
   endfunction

   task automatic check_models(input string tag);
      chk({tag, "/idx6"}, 32'(idx6), 32'(p6));
      chk({tag, "/out6"}, 32'(out6), onehot(p6, en));
      chk({tag, "/wrap6"}, 32'(wrap6), 32'(w6));
      chk({tag, "/err6"}, 32'(err6), 32'(e6));
      chk({tag, "/idx8"}, 32'(idx8), 32'(p8));
      chk({tag, "/out8"}, 32'(out8), onehot(p8, en));
      chk({tag, "/wrap8"}, 32'(wrap8), 32'(w8));
      chk({tag, "/err8"}, 32'(err8), 32'(e8));
   endtask

   task automatic tick(input string tag);
      model(6, p6, w6, e6);
      model(8, p8, w8, e8);
      @(posedge clk);
      #1;
      check_models(tag);
   endtask

   task automatic drive(input bit i_en, input bit i_mode, input bit i_lv,
                        input bit [2:0] i_idx, input bit i_step);
      en = i_en;
      mode = i_mode;
      load_valid = i_lv;
      load_idx = i_idx;
      step = i_step;
   endtask

   function automatic vec_t mk(input bit a_en, input bit a_mode, input bit a_lv,
                               input bit [2:0] a_idx, input bit a_step,
                               input int a_x, input bit a_w, input bit a_e);
      vec_t v;
      v.en = a_en; v.mode = a_mode; v.lv = a_lv; v.idx = a_idx;
      v.step = a_step; v.x_idx = a_x; v.x_wrap = a_w; v.x_err = a_e;
      return v;
   endfunction

   initial begin
      // direct mode: load 0..5, step ignored
      for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0, 1, 3'(i), 1, i, 0, 0));
      // rotate: load 4 then step x3
      tbl.push_back(mk(1, 1, 1, 3'd4, 0, 4, 0, 0));
      tbl.push_back(mk(1, 1, 0, 3'd0, 1, 5, 0, 0));
      tbl.push_back(mk(1, 1, 0, 3'd0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 3'd0, 1, 1, 0, 0));
      // bad load with step
      tbl.push_back(mk(1, 1, 1, 3'd2, 0, 2, 0, 0));
      tbl.push_back(mk(1, 1, 1, 3'd7, 1, 2, 0, 1));
      tbl.push_back(mk(1, 1, 0, 3'd0, 0, 2, 0, 0));
      // load and step together
      tbl.push_back(mk(1, 1, 1, 3'd5, 0, 5, 0, 0));
      tbl.push_back(mk(1, 1, 1, 3'd3, 1, 3, 0, 0));
      // enable gating while stepping
      tbl.push_back(mk(0, 1, 1, 3'd1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'd0, 1, 2, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'd0, 1, 3, 0, 0));
      tbl.push_back(mk(1, 1, 0, 3'd0, 0, 3, 0, 0));

      // reset values
      #3;
      chk("rst/out6", 32'(out6), 0);
      chk("rst/idx6", 32'(idx6), 0);
      chk("rst/out8", 32'(out8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 3'd0, 0);
      tick("post_rst");
      chk("post_rst/out6_lit", 32'(out6), 32'h01);

      // async reset mid-stream with ptr=4
      drive(1, 1, 1, 3'd4, 0);
      tick("pre_rst");
      drive(1, 1, 0, 3'd0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      p6 = 0; p8 = 0; w6 = 0; e6 = 0; w8 = 0; e8 = 0;
      chk("async_rst/out6", 32'(out6), 0);
      chk("async_rst/idx6", 32'(idx6), 0);
      chk("async_rst/wrap6", 32'(wrap6), 0);
      chk("async_rst/err6", 32'(err6), 0);
      chk("async_rst/idx8", 32'(idx8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 3'd0, 0);
      tick("rel");
      chk("rel/out6_lit", 32'(out6), 32'h01);

      // table-driven vectors for the NUM_OUT=6 instance
      foreach (tbl[k]) begin
         drive(tbl[k].en, tbl[k].mode, tbl[k].lv, tbl[k].idx, tbl[k].step);
         tick($sformatf("vec%0d", k));
         chk($sformatf("vec%0d/tidx", k), 32'(idx6), 32'(tbl[k].x_idx));
         chk($sformatf("vec%0d/twrap", k), 32'(wrap6), 32'(tbl[k].x_wrap));
         chk($sformatf("vec%0d/terr", k), 32'(err6), 32'(tbl[k].x_err));
         chk($sformatf("vec%0d/tout", k), 32'(out6),
             tbl[k].en ? (32'd1 << tbl[k].x_idx) : 32'd0);
      end
      chk("en_back/out6_lit", 32'(out6), 32'h08);

      // NUM_OUT=8 wrap on 7 -> 0
      drive(1, 1, 1, 3'd7, 0);
      tick("w8_load");
      drive(1, 1, 0, 3'd0, 1);
      tick("w8_step");
      chk("w8/wrap8_lit", 32'(wrap8), 1);
      chk("w8/out8_lit", 32'(out8), 32'h01);
      drive(1, 1, 0, 3'd0, 0);
      tick("w8_idle");
      chk("w8/wrap8_clr", 32'(wrap8), 0);

      // randomized traffic against the models
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               $urandom_range(0, 1));
         tick($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
